mem_lsu: RTL



---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/mem_lsu.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings, FSM states
// and the access-size helpers used by the FSM and the byte-lane logic.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Only funct3[1:0] selects the size; the reserved encodings 011/110/111 fall into W.
  function automatic lsu_size_t f3_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic size_is_misaligned(input logic [1:0] f3_lo, input logic [1:0] lo);
    case (f3_size(f3_lo))
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_low(input logic [1:0] f3_lo, input logic [1:0] lo);
    case (f3_size(f3_lo))
      SZ_H:    return {lo[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables and store replication on the way out,
// load shift plus sign/zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   byte_off,
  input  logic [N-1:0] wdata,
  input  logic [N-1:0] rdata,
  output logic [3:0]   be,
  output logic [N-1:0] wdata_rep,
  output logic [N-1:0] rdata_ext
);

  lsu_size_t  sz;
  logic [N-1:0] shifted;

  always_comb begin
    sz        = f3_size(funct3[1:0]);
    shifted   = rdata >> {byte_off, 3'b000};
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (sz)
      SZ_B: begin
        be        = 4'b0001 << byte_off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {{(N-8){1'b0}}, shifted[7:0]}
                              : {{(N-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << byte_off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {{(N-16){1'b0}}, shifted[15:0]}
                              : {{(N-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid transaction FSM with pipeline stall.
// Optional MEM_LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag misalign.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memRead,
  input  logic         memWrite,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic [N-1:0] MEMread,
  output logic         stall,
  output logic         misalign
);

  lsu_state_t   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         we_q, we_d;
  logic [N-1:0] memread_q, memread_d;
  logic         op;
  logic [1:0]   addr_lo;
  logic [3:0]   be;
  logic [N-1:0] wdata_rep;
  logic [N-1:0] rdata_ext;

  assign op = memRead | memWrite;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign addr_lo  = addr[1:0];
  assign misalign = misalign_q;
`else
  // Without the trap, misaligned H/W accesses silently round down to their natural boundary.
  assign addr_lo  = align_low(funct3[1:0], addr[1:0]);
  assign misalign = 1'b0;
`endif

  lsu_align #(.N(N)) u_align (
    .funct3    (funct3_q),
    .byte_off  (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (dmem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    memread_d = memread_q;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (op) begin
          addr_d   = {addr[N-1:2], addr_lo};
          funct3_d = funct3;
          wdata_d  = wdata;
          // A load wins when both requests are raised together.
          we_d     = memWrite & ~memRead;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
          if (size_is_misaligned(funct3[1:0], addr[1:0])) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (dmem_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid) begin
          memread_d = rdata_ext;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      memread_q <= '0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      memread_q <= memread_d;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Memory-port outputs are driven only while a request is being offered.
  always_comb begin
    dmem_req   = (state_q == REQ);
    dmem_we    = dmem_req & we_q;
    dmem_addr  = dmem_req ? {addr_q[N-1:2], 2'b00} : '0;
    dmem_be    = dmem_req ? be : 4'b0000;
    dmem_wdata = dmem_req ? wdata_rep : '0;
  end

  assign stall   = ((state_q == IDLE) & op) | (state_q == REQ) | (state_q == WAIT);
  assign MEMread = memread_q;

endmodule
